segment_scanner: RTL and testbench

SEGMENT_SCANNER -- requirements
Module: segment_scanner

---
 rtl/segment_scanner_pkg.sv | 22 ++
 rtl/segment_scanner_refresh_tick.sv | 30 +++
 rtl/segment_scanner.sv | 139 +++++++++++++
 tb/tb_segment_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/segment_scanner_pkg.sv
// Shared definitions for the 4-digit seven-segment scanner: display states,
// blanking patterns and the one-hot operation codes.
package segment_scanner_pkg;

    typedef enum logic [1:0] {
        ST_BLANK    = 2'd0,
        ST_SHOW_OP  = 2'd1,
        ST_SHOW_RES = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/segment_scanner_refresh_tick.sv
// Free-running refresh divider: pulses tick for one cycle every CLK_DIV cycles.
module refresh_tick #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/segment_scanner.sv
// Multiplexed 4-digit display driver: shows operation letters for a hold time
// after a new valid operation, then the numeric result; blanks on invalid codes.
module segment_scanner
    import segment_scanner_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] operation,
    input  logic [6:0] opletter0,
    input  logic [6:0] opletter1,
    input  logic [6:0] opletter2,
    input  logic [6:0] opletter3,
    input  logic [6:0] result0,
    input  logic [6:0] result1,
    input  logic [6:0] result2,
    input  logic [6:0] result3,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       show_op
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic          tick;
    logic          frame_end;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    op_q, op_prev_q;
    logic          op_valid, op_change;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          show_op_q;
    logic [6:0]    op_pat, res_pat;

    refresh_tick #(.CLK_DIV(CLK_DIV)) u_refresh_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    assign idx_d     = tick ? idx_q + 2'd1 : idx_q;
    assign frame_end = tick && (idx_q == 2'd3);
    assign op_valid  = is_valid_op(op_q);
    assign op_change = (op_q != op_prev_q);

    // An invalid code overrides everything; a change of code beats hold expiry.
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_d = state_q;
        hold_d  = hold_q;
        if (!op_valid) begin
            state_d = ST_BLANK;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    state_d = ST_SHOW_OP;
                    hold_d  = HW'(HOLD_FRAMES);
                end
                ST_SHOW_OP: begin
                    if (op_change) begin
                        hold_d = HW'(HOLD_FRAMES);
                    end else if (frame_end) begin
                        if (hold_q <= HW'(1)) begin
                            state_d = ST_SHOW_RES;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q - HW'(1);
                        end
                    end
                end
                ST_SHOW_RES: begin
                    if (op_change) begin
                        state_d = ST_SHOW_OP;
                        hold_d  = HW'(HOLD_FRAMES);
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    always_comb begin
        op_pat  = opletter0;
        res_pat = result0;
        case (idx_d)
            2'd1: begin op_pat = opletter1; res_pat = result1; end
            2'd2: begin op_pat = opletter2; res_pat = result2; end
            2'd3: begin op_pat = opletter3; res_pat = result3; end
            default: ;
        endcase
    end

    // Blanking is immediate; digit patterns only move on a refresh tick.
    always_comb begin
        seg_d = seg_q;
        an_d  = an_q;
        if (state_d == ST_BLANK) begin
            seg_d = SEG_BLANK;
            an_d  = AN_OFF;
        end else if (tick) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = (state_d == ST_SHOW_OP) ? op_pat : res_pat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= 2'd0;
            op_q      <= 3'b000;
            op_prev_q <= 3'b000;
            state_q   <= ST_BLANK;
            hold_q    <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            show_op_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            op_q      <= operation;
            op_prev_q <= op_q;
            state_q   <= state_d;
            hold_q    <= hold_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            show_op_q <= (state_d == ST_SHOW_OP);
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = 1'b1;
    assign show_op = show_op_q;

endmodule

// File: tb/tb_segment_scanner.sv
// Self-checking bench for segment_scanner: directed scenarios plus random
// operation/pattern traffic compared against a cycle-count based reference model.
module tb_segment_scanner;

    localparam int CLK_DIV     = 4;
    localparam int HOLD_FRAMES = 2;
    localparam int FRAME_CYC   = 4 * CLK_DIV;
    localparam int M_BLANK     = 0;
    localparam int M_OP        = 1;
    localparam int M_RES       = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] operation = 3'b000;
    logic [6:0] opl [4];
    logic [6:0] res [4];
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       show_op;

    int checks   = 0;
    int failures = 0;

    // Reference model: edges since reset release, mode, frames left.
    int         n;
    int         mode;
    int         left;
    logic [2:0] m_op, m_prev;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_show;

    int         guard;
    int         r;
    logic [2:0] valid_ops [3];

    always #5 clk = ~clk;

    segment_scanner #(.CLK_DIV(CLK_DIV), .HOLD_FRAMES(HOLD_FRAMES)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .operation(operation),
        .opletter0(opl[0]),
        .opletter1(opl[1]),
        .opletter2(opl[2]),
        .opletter3(opl[3]),
        .result0  (res[0]),
        .result1  (res[1]),
        .result2  (res[2]),
        .result3  (res[3]),
        .seg      (seg),
        .an       (an),
        .dp       (dp),
        .show_op  (show_op)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        mode   = M_BLANK;
        left   = 0;
        m_op   = 3'b000;
        m_prev = 3'b000;
        e_seg  = 7'h7F;
        e_an   = 4'hF;
        e_show = 1'b0;
    endtask

    // Tick edges are every CLK_DIV-th edge after release; the digit shown
    // after edge n is the tick count modulo 4; a frame ends when that count wraps to 0.
    task automatic model_edge();
        int idx;
        bit tk, fe, vld, chg;
        n++;
        tk  = (n % CLK_DIV) == 0;
        idx = (n / CLK_DIV) % 4;
        fe  = tk && (idx == 0);
        vld = (m_op == 3'b001) || (m_op == 3'b010) || (m_op == 3'b100);
        chg = (m_op != m_prev);
        if (!vld) begin
            mode = M_BLANK;
        end else if (mode == M_BLANK || chg) begin
            mode = M_OP;
            left = HOLD_FRAMES;
        end else if (mode == M_OP && fe) begin
            left--;
            if (left == 0) mode = M_RES;
        end
        m_prev = m_op;
        m_op   = operation;
        if (mode == M_BLANK) begin
            e_seg = 7'h7F;
            e_an  = 4'hF;
        end else if (tk) begin
            e_an  = 4'hF ^ (4'b0001 << idx);
            e_seg = (mode == M_OP) ? opl[idx] : res[idx];
        end
        e_show = (mode == M_OP);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, {19'd0, seg, an, dp, show_op}, {19'd0, e_seg, e_an, 1'b1, e_show});
    endtask

    initial begin
        valid_ops = '{3'b001, 3'b010, 3'b100};
        opl = '{7'h08, 7'h12, 7'h24, 7'h41};
        res = '{7'h40, 7'h79, 7'h25, 7'h30};
        model_reset();

        // Reset applied between edges and held across edges.
        #2 reset_n = 1'b0;
        #1 check("rst_async", {19'd0, seg, an, dp, show_op}, {19'd0, 7'h7F, 4'hF, 1'b1, 1'b0});
        repeat (2) @(posedge clk);
        #1 check("rst_held", {19'd0, seg, an, dp, show_op}, {19'd0, 7'h7F, 4'hF, 1'b1, 1'b0});
        #2 reset_n = 1'b1;
        model_reset();

        // Idle with no operation stays blank.
        for (int i = 0; i < 40; i++) step("idle_blank");

        // Add: letters scanned, then results after the hold.
        operation = 3'b001;
        for (int i = 0; i < 48; i++) step("add_scan");
        check("add_to_results", {31'd0, show_op}, 32'd0);

        // New op while showing results restarts the letter hold.
        operation = 3'b100;
        for (int i = 0; i < 4; i++) step("mul_reenter");
        check("mul_show_op", {31'd0, show_op}, 32'd1);
        for (int i = 0; i < 44; i++) step("mul_hold");

        // Change lands on the exact hold-expiry edge.
        operation = 3'b010;
        guard = 0;
        while (!(mode == M_OP && left == 1 && ((n + 2) % FRAME_CYC) == 0) && guard < 200) begin
            step("align");
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $error("FAIL align_timeout observed=%0d expected<200", guard);
        end
        operation = 3'b001;
        step("expiry_sample");
        step("expiry_edge");
        check("expiry_op_wins", {31'd0, show_op}, 32'd1);
        for (int i = 0; i < 20; i++) step("expiry_rehold");
        check("rehold_still_op", {31'd0, show_op}, 32'd1);
        for (int i = 0; i < 20; i++) step("expiry_done");
        check("rehold_done", {31'd0, show_op}, 32'd0);

        // Invalid code blanks on the cycle after it is sampled.
        operation = 3'b010;
        for (int i = 0; i < 6; i++) step("pre_invalid");
        check("pre_invalid_op", {31'd0, show_op}, 32'd1);
        operation = 3'b011;
        step("invalid_sample");
        step("invalid_blank");
        check("invalid_seg_an", {20'd0, seg, an, show_op}, {20'd0, 7'h7F, 4'hF, 1'b0});
        operation = 3'b010;
        for (int i = 0; i < 40; i++) step("sub_after_invalid");

        // Random operation and pattern traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 7) operation = valid_ops[$urandom_range(0, 2)];
                else       operation = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) opl[$urandom_range(0, 3)] = 7'($urandom);
            if ($urandom_range(0, 3) == 0) res[$urandom_range(0, 3)] = 7'($urandom);
            step("random");
        end

        // Reset pulse mid-frame between clock edges.
        operation = 3'b001;
        for (int i = 0; i < 30; i++) step("pre_reset");
        #2 reset_n = 1'b0;
        #1 check("rst_mid_frame", {19'd0, seg, an, dp, show_op}, {19'd0, 7'h7F, 4'hF, 1'b1, 1'b0});
        #1 reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) step("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
